// File: rtl/instr_fetch.sv
// instr_fetch: program-ROM reader; fetches, splits and hands instructions to execute over valid/ready.
// Optional FETCH_ERR_EN builds the sticky out-of-range fetch flag.
module instr_fetch #(
  parameter logic [4:0] START_ADDR = 5'd0,
  parameter logic [4:0] LAST_ADDR  = 5'd15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  output logic        rom_oe,
  output logic [4:0]  rom_addr,
  input  logic [15:0] rom_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [1:0]  instr_reg,
  output logic [3:0]  instr_code,
  output logic [7:0]  instr_data,
  input  logic        jmp_en,
  input  logic [4:0]  jmp_addr,
  output logic [4:0]  pc,
  output logic        fetch_err
);
  typedef enum logic [1:0] {IDLE, FETCH, VALID} state_t;
  state_t state, state_nx;
  logic [4:0] pc_nx;
  logic cap;
  logic unused_bits;
  assign unused_bits = ^rom_data[15:14];
  assign rom_oe = state == FETCH;
  assign instr_valid = state == VALID;
  assign rom_addr = pc;
  always_comb begin
    state_nx = state;
    pc_nx = pc;
    cap = 1'b0;
    case (state)
      IDLE:  state_nx = run ? FETCH : IDLE;
      FETCH: if (!jmp_en) begin
        cap = 1'b1;
        state_nx = VALID;
        pc_nx = pc >= LAST_ADDR ? START_ADDR : pc + 5'd1;
      end
      VALID: state_nx = instr_ready ? (run ? FETCH : IDLE) : VALID;
      default: state_nx = IDLE;
    endcase
    pc_nx = jmp_en ? jmp_addr : pc_nx;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      pc <= START_ADDR;
    end else begin
      state <= state_nx;
      pc <= pc_nx;
    end
  // A jump during FETCH discards the word, so capture only on a completed fetch
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      instr_reg <= '0;
      instr_code <= '0;
      instr_data <= '0;
    end else if (cap) begin
      instr_reg <= rom_data[13:12];
      instr_code <= rom_data[11:8];
      instr_data <= rom_data[7:0];
    end
`ifdef FETCH_ERR_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) fetch_err <= 1'b0;
    else if (state == FETCH && pc > LAST_ADDR) fetch_err <= 1'b1;
`else
  assign fetch_err = 1'b0;
`endif
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: randomized bench for instr_fetch against a transaction-level reference model.
module tb_instr_fetch;
  logic clk = 0, rst_n = 0, run = 0, instr_ready = 0, jmp_en = 0;
  logic [4:0] jmp_addr = 0;
  logic rom_oe, instr_valid, fetch_err;
  logic [4:0] rom_addr, pc;
  logic [15:0] rom_data;
  logic [1:0] instr_reg;
  logic [3:0] instr_code;
  logic [7:0] instr_data;
  logic [15:0] rom [32];
  int errors = 0, checks = 0;
  int m_st;
  logic [4:0] m_pc;
  logic [15:0] m_word;
  logic m_err;
  logic [15:0] w;
  logic hv;
  logic [7:0] hd;
  always #5 clk = ~clk;
  assign rom_data = rom_oe ? rom[rom_addr] : 16'h0000;
  instr_fetch dut (
    .clk(clk), .rst_n(rst_n), .run(run), .rom_oe(rom_oe), .rom_addr(rom_addr),
    .rom_data(rom_data), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_reg(instr_reg), .instr_code(instr_code), .instr_data(instr_data),
    .jmp_en(jmp_en), .jmp_addr(jmp_addr), .pc(pc), .fetch_err(fetch_err)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [4:0] next_pc(input logic [4:0] p);
    return p >= 5'd15 ? 5'd0 : p + 5'd1;
  endfunction
  task automatic model_reset();
    m_st = 0; m_pc = 0; m_word = 0; m_err = 0;
  endtask
  // Model phases: 0 idle, 1 reading ROM, 2 holding a delivered word
  task automatic model_step(input logic r, input logic rd, input logic j, input logic [4:0] ja);
    if (m_st == 0) begin
      if (r) m_st = 1;
      if (j) m_pc = ja;
    end else if (m_st == 1) begin
      if (m_pc > 5'd15) m_err = 1;
      if (j) m_pc = ja;
      else begin
        m_word = rom[m_pc];
        m_pc = next_pc(m_pc);
        m_st = 2;
      end
    end else begin
      if (rd) m_st = r ? 1 : 0;
      if (j) m_pc = ja;
    end
  endtask
  task automatic compare_all();
    check("instr_valid", instr_valid, m_st == 2);
    check("rom_oe", rom_oe, m_st == 1);
    check("pc", pc, m_pc);
    check("rom_addr", rom_addr, m_pc);
    check("instr_reg", instr_reg, m_word[13:12]);
    check("instr_code", instr_code, m_word[11:8]);
    check("instr_data", instr_data, m_word[7:0]);
`ifdef FETCH_ERR_EN
    check("fetch_err", fetch_err, m_err);
`else
    check("fetch_err", fetch_err, 0);
`endif
  endtask
  task automatic cyc(input logic r, input logic rd, input logic j, input logic [4:0] ja);
    run = r; instr_ready = rd; jmp_en = j; jmp_addr = ja;
    @(posedge clk);
    model_step(r, rd, j, ja);
    @(negedge clk);
    compare_all();
  endtask
  task automatic do_reset();
    run = 0; instr_ready = 0; jmp_en = 0; jmp_addr = 0;
    rst_n = 0;
    model_reset();
    @(negedge clk);
    compare_all();
    rst_n = 1;
    @(negedge clk);
  endtask
  initial begin
    for (int i = 0; i < 32; i++) rom[i] = i < 16 ? 16'($urandom) : 16'h0000;
    rom[0] = 16'h1234;
    do_reset();
    cyc(1, 1, 0, 0);
    check("lat_valid_n1", instr_valid, 0);
    cyc(1, 1, 0, 0);
    check("lat_valid_n2", instr_valid, 1);
    check("first_reg", instr_reg, 2'b01);
    check("first_code", instr_code, 4'h2);
    check("first_data", instr_data, 8'h34);
    check("first_pc", pc, 5'd1);
    for (int k = 1; k < 3; k++) begin
      cyc(1, 1, 0, 0);
      cyc(1, 1, 0, 0);
    end
    cyc(1, 1, 0, 0);
    check("fetching_3", rom_addr, 5'd3);
    cyc(1, 1, 1, 5'd9);
    check("jump_stays_fetch", rom_oe, 1);
    cyc(1, 0, 0, 0);
    check("jump_data", instr_data, rom[9][7:0]);
    check("jump_pc", pc, 5'd10);
    hv = instr_valid; hd = instr_data;
    for (int k = 0; k < 5; k++) begin
      cyc(1, 0, 0, 0);
      check("hold_valid", instr_valid, hv);
      check("hold_data", instr_data, hd);
    end
    cyc(1, 1, 1, 5'd20);
    check("to_fetch_20", rom_addr, 5'd20);
    cyc(1, 0, 0, 0);
    check("oor_word", {instr_reg, instr_code, instr_data}, 14'h0);
`ifdef FETCH_ERR_EN
    check("oor_err", fetch_err, 1);
`else
    check("oor_err", fetch_err, 0);
`endif
    cyc(1, 1, 0, 0);
    check("wrap_addr", rom_addr, 5'd0);
    cyc(1, 1, 0, 0);
    #2 rst_n = 0;
    #1;
    model_reset();
    check("arst_valid", instr_valid, 0);
    check("arst_pc", pc, 0);
    check("arst_oe", rom_oe, 0);
    @(negedge clk);
    rst_n = 1;
    cyc(1, 1, 0, 0);
    check("post_rst_addr", rom_addr, 5'd0);
    for (int k = 0; k < 40; k++) cyc(1, 1, 0, 0);
    for (int k = 0; k < 400; k++)
      cyc($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 6,
          $urandom_range(0, 9) == 0, 5'($urandom_range(0, 31)));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
